// File: rtl/csa_resolve_simd.sv
// Resolves a SIMD carry-save pair (ps, sc) into lane-wise binary sums z = ps + (sc << 1),
// one CHUNK_W-bit slice per cycle, with carries confined to 32/64/128/256-bit lanes.
module csa_resolve_simd #(
  parameter int unsigned DATA_W  = 256,
  parameter int unsigned CHUNK_W = 64
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] ps_i,
  input  logic [DATA_W-1:0] sc_i,
  input  logic [2:0]        width_i,  // {is256, is128, is64}; all zero selects 32-bit lanes
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] z_o
);

  localparam int unsigned NCHUNK = DATA_W / CHUNK_W;
  localparam int unsigned NWORD  = CHUNK_W / 32;
  localparam int unsigned NWTOT  = DATA_W / 32;
  localparam int unsigned CntW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

  state_e            state_q;
  logic [DATA_W-1:0] a_q, b_q, z_q;
  logic [CntW-1:0]   cnt_q;
  logic              carry_q;
  logic [1:0]        lg_q;  // log2(lane width / 32)

  logic [1:0]        lg_in;
  logic [DATA_W-1:0] b_in;
  logic [DATA_W-1:0] a_next;
  logic              carry_d;

  // A 32-bit word starts a lane when its word index is a multiple of the lane's word count.
  function automatic logic lane_start(input int unsigned word, input logic [1:0] lg);
    return (word & ((32'd1 << lg) - 32'd1)) == 32'd0;
  endfunction

  always_comb begin
    if (width_i[2])      lg_in = 2'd3;
    else if (width_i[1]) lg_in = 2'd2;
    else if (width_i[0]) lg_in = 2'd1;
    else                 lg_in = 2'd0;
  end

  // Shifted saved-carry with the bit that crossed into each lane's LSB dropped.
  always_comb begin
    b_in = sc_i << 1;
    for (int unsigned k = 0; k < NWTOT; k++) begin
      if (lane_start(k, lg_in)) b_in[k*32] = 1'b0;
    end
  end

  // Chunk adder: NWORD chained 32-bit adders, the first fed from the carry register.
  always_comb begin
    logic          c;
    logic [32:0]   s;
    int unsigned   base;
    base    = 32'(cnt_q) * NWORD;
    a_next  = a_q;
    c       = carry_q;
    s       = '0;
    for (int unsigned i = 0; i < NWORD; i++) begin
      if (lane_start(base + i, lg_q)) c = 1'b0;
      s = {1'b0, a_q[(base+i)*32 +: 32]} + {1'b0, b_q[(base+i)*32 +: 32]} + {32'd0, c};
      a_next[(base+i)*32 +: 32] = s[31:0];
      c = s[32];
    end
    carry_d = c;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      z_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      lg_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (valid_i) begin
            a_q     <= ps_i;
            b_q     <= b_in;
            lg_q    <= lg_in;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            state_q <= StAdd;
          end
        end
        StAdd: begin
          // Partial sums accumulate in a_q; z_q only sees the finished result.
          a_q     <= a_next;
          carry_q <= carry_d;
          cnt_q   <= cnt_q + CntW'(1);
          if (cnt_q == CntW'(NCHUNK - 1)) begin
            z_q     <= a_next;
            state_q <= StDone;
          end
        end
        StDone: begin
          if (ready_i) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ready_o = (state_q == StIdle);
  assign valid_o = (state_q == StDone);
  assign z_o     = z_q;

endmodule

// File: tb/tb_csa_resolve_simd.sv
// Randomised bench for csa_resolve_simd against a lane-arithmetic reference model.
module tb_csa_resolve_simd;

  logic         clk = 1'b0;
  logic         rst_n_i = 1'b0;
  logic         valid_i = 1'b0;
  logic         ready_i = 1'b0;
  logic [2:0]   width_i = 3'd0;
  logic [255:0] ps_i = '0;
  logic [255:0] sc_i = '0;
  logic         ready_o, valid_o;
  logic [255:0] z_o;

  csa_resolve_simd #(.DATA_W(256), .CHUNK_W(64)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .ps_i    (ps_i),
    .sc_i    (sc_i),
    .width_i (width_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .z_o     (z_o)
  );

  always #5 clk = ~clk;

  int           checks = 0;
  int           failures = 0;
  logic [255:0] exp_z = '0;
  logic [255:0] hold_z = '0;
  bit           chk_en = 1'b0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Each lane is an independent W-bit integer: (ps + 2*sc) mod 2^W.
  function automatic logic [255:0] model(input logic [255:0] ps, input logic [255:0] sc,
                                         input logic [2:0] w);
    int unsigned  lw;
    logic [255:0] mask, z, p, s, r;
    lw   = w[2] ? 256 : w[1] ? 128 : w[0] ? 64 : 32;
    mask = (lw == 256) ? '1 : ((256'd1 << lw) - 256'd1);
    z    = '0;
    for (int l = 0; l < 256 / int'(lw); l++) begin
      p = (ps >> (l * lw)) & mask;
      s = (sc >> (l * lw)) & mask;
      r = (p + (s << 1)) & mask;
      z |= r << (l * lw);
    end
    return z;
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Output is checked every cycle against the last result the model says must be visible.
  always @(negedge clk) begin
    if (chk_en) begin
      if (valid_o) hold_z = exp_z;
      check("z_track", z_o, hold_z);
      check("rv_exclusive", 256'(valid_o && ready_o), 256'd0);
    end
  end

  task automatic run(input logic [255:0] ps, input logic [255:0] sc, input logic [2:0] w,
                     input int hold, input bit noisy);
    int n;
    n = 0;
    while (!ready_o && n < 20) begin @(negedge clk); n++; end
    check("ready_idle", 256'(ready_o), 256'd1);
    ps_i = ps; sc_i = sc; width_i = w; valid_i = 1'b1;
    @(posedge clk);
    exp_z = model(ps, sc, w);
    @(negedge clk);
    valid_i = 1'b0;
    ps_i = rnd256(); sc_i = rnd256(); width_i = 3'($urandom);
    check("busy_ready", 256'(ready_o), 256'd0);
    n = 0;
    while (!valid_o && n < 20) begin @(negedge clk); n++; end
    check("latency", 256'(n), 256'd4);
    check("z_result", z_o, exp_z);
    for (int i = 0; i < hold; i++) begin
      ready_i = 1'b0;
      if (noisy) begin
        ps_i = ~ps_i; sc_i = rnd256(); valid_i = ~valid_i;
      end
      @(negedge clk);
      check("bp_ready", 256'(ready_o), 256'd0);
      check("bp_valid", 256'(valid_o), 256'd1);
      check("bp_z", z_o, exp_z);
    end
    ready_i = 1'b1;
    valid_i = noisy;
    @(negedge clk);
    check("handoff_valid", 256'(valid_o), 256'd0);
    check("handoff_ready", 256'(ready_o), 256'd1);
    ready_i = 1'b0;
    valid_i = 1'b0;
  endtask

  localparam logic [255:0] T1_PS = {8{32'hFFFF_FFFF}};
  localparam logic [255:0] T1_SC = {8{32'h1}};
  localparam logic [255:0] T2_PS = {192'd0, 64'hFFFF_FFFF_FFFF_FFFF};
  localparam logic [255:0] T2_SC = 256'd1;
  localparam logic [255:0] T2_Z  = 256'h1_0000000000000001;
  localparam logic [255:0] T3_PS = {64'd0, 64'd0, 64'd5, 64'hFFFF_FFFF_FFFF_FFFF};
  localparam logic [255:0] T3_Z  = {64'd0, 64'd0, 64'd5, 64'd1};
  localparam logic [255:0] T4_SC = 256'd1 << 127;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_valid", 256'(valid_o), 256'd0);
    check("rst_ready", 256'(ready_o), 256'd1);
    check("rst_z", z_o, 256'd0);
    rst_n_i = 1'b1;
    chk_en  = 1'b1;

    check("model_t1", model(T1_PS, T1_SC, 3'b000), {8{32'h1}});
    check("model_t2", model(T2_PS, T2_SC, 3'b100), T2_Z);
    check("model_t3", model(T3_PS, 256'd1, 3'b001), T3_Z);
    check("model_t4", model(256'd0, T4_SC, 3'b010), 256'd0);

    run(T1_PS, T1_SC, 3'b000, 0, 1'b0);
    check("t1_z", z_o, {8{32'h1}});
    run(T2_PS, T2_SC, 3'b100, 0, 1'b0);
    check("t2_z", z_o, T2_Z);
    run(T3_PS, 256'd1, 3'b001, 1, 1'b0);
    check("t3_z", z_o, T3_Z);
    run(256'd0, T4_SC, 3'b010, 0, 1'b0);
    check("t4_z", z_o, 256'd0);
    run(rnd256(), rnd256(), 3'b001, 3, 1'b1);

    // Reset landing on the second ADD cycle.
    chk_en = 1'b0;
    ps_i = T2_PS; sc_i = T2_SC; width_i = 3'b100; valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    @(negedge clk);
    rst_n_i = 1'b0;
    @(negedge clk);
    check("t6_valid", 256'(valid_o), 256'd0);
    check("t6_z", z_o, 256'd0);
    check("t6_ready", 256'(ready_o), 256'd1);
    rst_n_i = 1'b1;
    hold_z  = '0;
    chk_en  = 1'b1;
    run(T2_PS, T2_SC, 3'b100, 0, 1'b0);
    check("t6_t2_z", z_o, T2_Z);

    for (int t = 0; t < 60; t++) begin
      logic [255:0] p, s;
      p = ($urandom_range(0, 3) == 0) ? ~256'd0 : rnd256();
      s = ($urandom_range(0, 3) == 0) ? {8{32'h1}} : rnd256();
      run(p, s, 3'($urandom), $urandom_range(0, 2), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
